// File: rtl/rx_merge_logic.sv
// rx_merge_logic: drains the D0/D1 output FIFOs, merges both streams round-robin into a
// registered valid/ready buffer, and tracks per-source word counts and FSM status.
module rx_merge_logic #(
  parameter int DATA_WIDTH = 6,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_fifo_D0,
  input  logic                  empty_fifo_D1,
  input  logic [DATA_WIDTH-1:0] data_out_D0,
  input  logic [DATA_WIDTH-1:0] data_out_D1,
  input  logic                  error_D0,
  input  logic                  error_D1,
  input  logic                  out_ready,
  output logic                  D0_pop,
  output logic                  D1_pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  out_src,
  output logic [CNT_WIDTH-1:0]  count_D0,
  output logic [CNT_WIDTH-1:0]  count_D1,
  output logic                  error_out,
  output logic                  active_out,
  output logic                  idle_out
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W:0] DEPTH_L = (OCC_W+1)'(BUF_DEPTH);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH:0]   r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_inflight;
  logic                  r_inflight_src;
  logic                  r_rr_d1;
  logic [CNT_WIDTH-1:0]  r_cnt_d0;
  logic [CNT_WIDTH-1:0]  r_cnt_d1;
  logic [OCC_W:0]        w_credit;
  logic                  w_pop_ok;
  logic                  w_idle_cond;
  logic                  w_flush;
  logic                  w_out_pop;
  logic [DATA_WIDTH-1:0] w_cap_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; init outranks any pending FIFO error
  always_comb begin
    w_idle_cond  = empty_fifo_D0 & empty_fifo_D1 & (r_occ == '0) & ~r_inflight;
    w_next_state = r_state;
    if (init) begin
      w_next_state = ST_INIT;
    end else begin
      case (r_state)
        ST_RESET:  w_next_state = ST_IDLE;
        ST_INIT:   w_next_state = ST_IDLE;
        ST_IDLE:   w_next_state = (error_D0 | error_D1) ? ST_ERROR :
                                  (w_idle_cond ? ST_IDLE : ST_ACTIVE);
        ST_ACTIVE: w_next_state = (error_D0 | error_D1) ? ST_ERROR :
                                  (w_idle_cond ? ST_IDLE : ST_ACTIVE);
        ST_ERROR:  w_next_state = ST_ERROR;
        default:   w_next_state = ST_RESET;
      endcase
    end
  end

  // Outputs: pop arbitration under buffer credit, status decode, buffer head
  always_comb begin
    w_credit = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight};
    if ((r_state == ST_IDLE) || (r_state == ST_ACTIVE)) begin
      w_pop_ok = (w_credit < DEPTH_L);
    end else begin
      w_pop_ok = 1'b0;
    end
    D0_pop     = w_pop_ok & ~empty_fifo_D0 & (empty_fifo_D1 | ~r_rr_d1);
    D1_pop     = w_pop_ok & ~empty_fifo_D1 & (empty_fifo_D0 | r_rr_d1);
    error_out  = (r_state == ST_ERROR);
    active_out = (r_state == ST_ACTIVE);
    idle_out   = (r_state == ST_IDLE);
    out_valid  = (r_occ != '0);
    if (out_valid) begin
      data_out = r_buf[r_rd_ptr][DATA_WIDTH-1:0];
      out_src  = r_buf[r_rd_ptr][DATA_WIDTH];
    end else begin
      data_out = '0;
      out_src  = 1'b0;
    end
    count_D0   = r_cnt_d0;
    count_D1   = r_cnt_d1;
    w_out_pop  = out_valid & out_ready;
    w_flush    = init | (r_state == ST_INIT);
    w_cap_data = r_inflight_src ? data_out_D1 : data_out_D0;
  end

  // Datapath: in-flight tracking, capture into the buffer tail, head retire, counters
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_occ          <= '0;
      r_inflight     <= 1'b0;
      r_inflight_src <= 1'b0;
      r_rr_d1        <= 1'b0;
      r_cnt_d0       <= '0;
      r_cnt_d1       <= '0;
    end else begin
      r_inflight     <= D0_pop | D1_pop;
      r_inflight_src <= D1_pop;
      if (D0_pop | D1_pop) begin
        r_rr_d1 <= D0_pop;
      end
      if (r_inflight) begin
        r_buf[r_wr_ptr] <= {r_inflight_src, w_cap_data};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1'b1);
        if (r_inflight_src) begin
          r_cnt_d1 <= r_cnt_d1 + CNT_WIDTH'(1'b1);
        end else begin
          r_cnt_d0 <= r_cnt_d0 + CNT_WIDTH'(1'b1);
        end
      end
      if (w_out_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
      end
      r_occ <= r_occ + OCC_W'(r_inflight) - OCC_W'(w_out_pop);
    end
  end

endmodule

// File: tb/tb_rx_merge_logic.sv
// Self-checking bench for rx_merge_logic: FIFO models feed D0/D1, a scoreboard holds the
// expected merged stream, and an FSM vector table plus directed sequences cover corner cases.
module tb_rx_merge_logic;

  localparam int DW = 6;

  logic          clk;
  logic          reset;
  logic          init;
  logic          empty_fifo_D0;
  logic          empty_fifo_D1;
  logic [DW-1:0] data_out_D0;
  logic [DW-1:0] data_out_D1;
  logic          error_D0;
  logic          error_D1;
  logic          out_ready;
  logic          D0_pop;
  logic          D1_pop;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          out_src;
  logic [7:0]    count_D0;
  logic [7:0]    count_D1;
  logic          error_out;
  logic          active_out;
  logic          idle_out;

  rx_merge_logic #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_fifo_D0(empty_fifo_D0), .empty_fifo_D1(empty_fifo_D1),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .error_D0(error_D0), .error_D1(error_D1), .out_ready(out_ready),
    .D0_pop(D0_pop), .D1_pop(D1_pop), .data_out(data_out),
    .out_valid(out_valid), .out_src(out_src),
    .count_D0(count_D0), .count_D1(count_D1),
    .error_out(error_out), .active_out(active_out), .idle_out(idle_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source FIFO models: read data appears the cycle after a pop
  logic [DW-1:0] mem0 [1024];
  logic [DW-1:0] mem1 [1024];
  int            wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  logic          flush_req = 1'b0;

  assign empty_fifo_D0 = (wp0 == rp0);
  assign empty_fifo_D1 = (wp1 == rp1);

  always @(posedge clk) begin
    if (flush_req) begin
      rp0 <= wp0;
      rp1 <= wp1;
    end else begin
      if (D0_pop && (rp0 != wp0)) begin
        data_out_D0 <= mem0[rp0];
        rp0         <= rp0 + 1;
      end
      if (D1_pop && (rp1 != wp1)) begin
        data_out_D1 <= mem1[rp1];
        rp1         <= rp1 + 1;
      end
    end
  end

  int            errors = 0;
  int            checks = 0;
  logic [DW:0]   sb [$];
  logic [DW-1:0] e0 [$];
  logic [DW-1:0] e1 [$];
  bit            pop_src_q [$];
  int            pop_cyc_q [$];
  bit            act_log [1024];
  bit            idle_log [1024];
  int            cyc_n, first_valid, last_hs, valid_cycles;

  typedef struct packed {
    logic       rst;
    logic       ini;
    logic       er0;
    logic       er1;
    logic [2:0] st;   // {error_out, active_out, idle_out} seen before this vector's edge
  } vec_t;
  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_logs();
    cyc_n = 0;
    first_valid = -1;
    last_hs = -1;
    valid_cycles = 0;
    pop_src_q.delete();
    pop_cyc_q.delete();
  endtask

  // One clock: observe at the falling edge, then advance past the rising edge
  task automatic cyc();
    logic [DW:0] exp_w;
    @(negedge clk);
    cyc_n++;
    if (cyc_n < 1024) begin
      act_log[cyc_n]  = active_out;
      idle_log[cyc_n] = idle_out;
    end
    if (out_valid) begin
      valid_cycles++;
      if (first_valid < 0) first_valid = cyc_n;
    end
    if (D0_pop || D1_pop) begin
      check("pop_exclusive", 32'(D0_pop & D1_pop), 32'd0);
      check("pop_nonempty", 32'((D0_pop & empty_fifo_D0) | (D1_pop & empty_fifo_D1)), 32'd0);
      pop_src_q.push_back(D1_pop);
      pop_cyc_q.push_back(cyc_n);
    end
    if (out_valid && out_ready && !reset) begin
      last_hs = cyc_n;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got src=%0d data=0x%0h, none expected", out_src, data_out);
      end else begin
        exp_w = sb.pop_front();
        check("merge_word", 32'({out_src, data_out}), 32'(exp_w));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic apply_reset();
    reset = 1'b1; init = 1'b0; error_D0 = 1'b0; error_D1 = 1'b0; out_ready = 1'b0;
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    cyc();
    check("reset_outputs", 32'({D0_pop, D1_pop, data_out, out_valid, out_src, count_D0,
                                count_D1, error_out, active_out, idle_out}), 32'd0);
    sb.delete(); e0.delete(); e1.delete();
    clear_logs();
  endtask

  task automatic load(input bit src, input int n, input int n_exp);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom_range(0, 63));
      if (!src) begin
        mem0[wp0] = w; wp0++;
        if (i < n_exp) e0.push_back(w);
      end else begin
        mem1[wp1] = w; wp1++;
        if (i < n_exp) e1.push_back(w);
      end
    end
  endtask

  // Expected merge order when all words are present up front: alternate from D0,
  // fall back to whichever source still has words
  task automatic expect_rr();
    bit pref1;
    pref1 = 1'b0;
    while ((e0.size() != 0) || (e1.size() != 0)) begin
      if ((e0.size() != 0) && (!pref1 || (e1.size() == 0))) begin
        sb.push_back({1'b0, e0.pop_front()});
        pref1 = 1'b1;
      end else begin
        sb.push_back({1'b1, e1.pop_front()});
        pref1 = 1'b0;
      end
    end
  endtask

  initial begin
    int bad, budget, p, l;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b001};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b001};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b100};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b100};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b100};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b001};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b100};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b000};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b001};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b001};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b001};

    reset = 1'b1; init = 1'b0; error_D0 = 1'b0; error_D1 = 1'b0; out_ready = 1'b0;

    // FSM vectors with both FIFOs empty: reset/init/error priorities and status lag
    apply_reset();
    for (int i = 0; i < 19; i++) begin
      reset = tbl[i].rst; init = tbl[i].ini; error_D0 = tbl[i].er0; error_D1 = tbl[i].er1;
      check($sformatf("fsm_vec%0d", i), 32'({error_out, active_out, idle_out}), 32'(tbl[i].st));
      cyc();
    end

    // D0 only: three back-to-back pops, in-order delivery, two-cycle latency
    apply_reset();
    load(1'b0, 3, 3);
    expect_rr();
    out_ready = 1'b1;
    reset = 1'b0;
    run(20);
    check("d0_pop_count", 32'(pop_src_q.size()), 32'd3);
    if (pop_src_q.size() == 3) begin
      check("d0_pop_consecutive", 32'(pop_cyc_q[2] - pop_cyc_q[0]), 32'd2);
      check("d0_pop_src", 32'({pop_src_q[0], pop_src_q[1], pop_src_q[2]}), 32'd0);
      check("min_latency", 32'(first_valid - pop_cyc_q[0]), 32'd2);
    end
    check("d0_drained", 32'(sb.size()), 32'd0);
    check("d0_count", 32'(count_D0), 32'd3);
    check("d0_idle_after", 32'(idle_out), 32'd1);

    // Both sources with four words: alternation, ACTIVE throughout, then IDLE
    apply_reset();
    load(1'b0, 4, 4);
    load(1'b1, 4, 4);
    expect_rr();
    out_ready = 1'b1;
    reset = 1'b0;
    run(30);
    check("rr_pop_count", 32'(pop_src_q.size()), 32'd8);
    bad = 0;
    for (int i = 0; i < pop_src_q.size(); i++) if (pop_src_q[i] != i[0]) bad++;
    check("rr_alternate", 32'(bad), 32'd0);
    check("rr_drained", 32'(sb.size()), 32'd0);
    check("rr_counts", 32'({count_D0, count_D1}), 32'h0404);
    if (pop_cyc_q.size() > 0 && last_hs > 0 && last_hs < 1000) begin
      p = pop_cyc_q[0];
      l = last_hs;
      bad = 0;
      for (int c = p + 1; c <= l + 1; c++) if (!act_log[c]) bad++;
      check("active_throughout", 32'(bad), 32'd0);
      check("idle_after_drain", 32'(idle_log[l + 2]), 32'd1);
    end else begin
      check("rr_activity_seen", 32'd0, 32'd1);
    end

    // Backpressure: only BUF_DEPTH pops while ready is low, nothing lost afterwards
    apply_reset();
    load(1'b0, 6, 6);
    load(1'b1, 6, 6);
    expect_rr();
    reset = 1'b0;
    run(20);
    check("bp_pop_count", 32'(pop_src_q.size()), 32'd4);
    check("bp_valid_held", 32'(out_valid), 32'd1);
    check("bp_head", 32'({out_src, data_out}), 32'(sb[0]));
    out_ready = 1'b1;
    run(40);
    check("bp_total_pops", 32'(pop_src_q.size()), 32'd12);
    check("bp_drained", 32'(sb.size()), 32'd0);
    check("bp_counts", 32'({count_D0, count_D1}), 32'h0606);

    // Error mid-stream: pops stop, buffered words drain, sticky until init
    apply_reset();
    load(1'b0, 4, 2);
    load(1'b1, 4, 2);
    expect_rr();
    out_ready = 1'b1;
    reset = 1'b0;
    budget = 20;
    while (pop_src_q.size() < 3 && budget > 0) begin
      cyc();
      budget--;
    end
    check("err_wait_pops", 32'(budget > 0), 32'd1);
    error_D1 = 1'b1;
    cyc();
    error_D1 = 1'b0;
    check("err_flag_next", 32'({error_out, active_out, idle_out}), 32'b100);
    run(15);
    check("err_pops_stop", 32'(pop_src_q.size()), 32'd4);
    check("err_drained", 32'(sb.size()), 32'd0);
    check("err_counts", 32'({count_D0, count_D1}), 32'h0202);
    check("err_sticky", 32'(error_out), 32'd1);
    init = 1'b1;
    run(2);
    check("init_state", 32'({error_out, active_out, idle_out, out_valid}), 32'd0);
    check("init_counts", 32'({count_D0, count_D1}), 32'd0);

    // Counter wrap at 256 D0 words
    apply_reset();
    load(1'b0, 256, 256);
    expect_rr();
    out_ready = 1'b1;
    reset = 1'b0;
    budget = 600;
    while (count_D0 != 8'd255 && budget > 0) begin
      cyc();
      budget--;
    end
    check("wrap_reach_255", 32'(budget > 0), 32'd1);
    run(20);
    check("wrap_count", 32'(count_D0), 32'd0);
    check("wrap_drained", 32'(sb.size()), 32'd0);

    // Reset with a word in flight: the word must never reach the output
    clear_logs();
    load(1'b0, 1, 0);
    budget = 10;
    while (pop_src_q.size() == 0 && budget > 0) begin
      cyc();
      budget--;
    end
    check("inflight_pop_seen", 32'(budget > 0), 32'd1);
    apply_reset();
    out_ready = 1'b1;
    reset = 1'b0;
    run(10);
    check("inflight_dropped", 32'(valid_cycles), 32'd0);
    check("inflight_count", 32'(count_D0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
